mgmt_soc_ram_arb: RTL and testbench

- Parametrised on-die work RAM for the management SoC. It restores the SoC's DFF-RAM port (today tied off to zero).
- Adds a shared read-only port for housekeeping, arbitrated against the SoC port.
- Adds a hardware clear engine that zeroes the array after reset or on software request.
- Sits beside the management core in the core_clk domain. Instantiated by the management wrapper.

---
 rtl/mgmt_ram_pkg.sv | 15 +
 rtl/mgmt_soc_ram_arb_if.sv | 27 ++
 rtl/mgmt_ram_array.sv | 50 +++++
 rtl/mgmt_soc_ram_arb.sv | 112 +++++++++++
 tb/tb_mgmt_soc_ram_arb.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mgmt_ram_pkg.sv
// Shared types and constants for the management SoC work RAM.
package mgmt_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram_state_e;

    localparam int STARVE_W = 8;

    function automatic int lane_cnt(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mgmt_soc_ram_arb_if.sv
// SoC DFF-RAM port plus the housekeeping read-only port.
interface mgmt_soc_ram_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic                  soc_en;
    logic [DATA_W/8-1:0]   soc_we;
    logic [ADDR_W-1:0]     soc_a;
    logic [DATA_W-1:0]     soc_di;
    logic [DATA_W-1:0]     soc_do;
    logic                  ro_req;
    logic [ADDR_W-1:0]     ro_addr;
    logic                  ro_ready;
    logic                  ro_valid;
    logic [DATA_W-1:0]     ro_data;
    logic                  ro_err;

    modport master (
        output soc_en, soc_we, soc_a, soc_di, ro_req, ro_addr,
        input  soc_do, ro_ready, ro_valid, ro_data, ro_err
    );

    modport slave (
        input  soc_en, soc_we, soc_a, soc_di, ro_req, ro_addr,
        output soc_do, ro_ready, ro_valid, ro_data, ro_err
    );
endinterface

// File: rtl/mgmt_ram_array.sv
// DEPTH x DATA_W flop storage: one byte-enabled write port, two registered
// read-first read ports. Out-of-range writes drop, out-of-range reads give 0.
module mgmt_ram_array
    import mgmt_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W/8-1:0] we,
    input  logic [ADDR_W-1:0]   wa,
    input  logic [DATA_W-1:0]   wd,
    input  logic                a_en,
    input  logic                a_zero,
    input  logic [ADDR_W-1:0]   a_addr,
    output logic [DATA_W-1:0]   a_do,
    input  logic                b_en,
    input  logic [ADDR_W-1:0]   b_addr,
    output logic [DATA_W-1:0]   b_do
);
    localparam int NB = lane_cnt(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic w_ok, a_ok, b_ok;

    assign w_ok = {1'b0, wa} < DEPTH_C;
    assign a_ok = {1'b0, a_addr} < DEPTH_C;
    assign b_ok = {1'b0, b_addr} < DEPTH_C;

    // Storage is intentionally not reset; the clear engine owns initialisation.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we[i] && w_ok) mem[wa][i*8 +: 8] <= wd[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_do <= '0;
            b_do <= '0;
        end else begin
            if (a_en) a_do <= (a_zero || !a_ok) ? '0 : mem[a_addr];
            if (b_en) b_do <= b_ok ? mem[b_addr] : '0;
        end
    end

endmodule

// File: rtl/mgmt_soc_ram_arb.sv
// Management SoC work RAM: SoC port with absolute priority, arbitrated
// housekeeping read port with starvation timeout, and a hardware clear engine.
module mgmt_soc_ram_arb
    import mgmt_ram_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 256,
    parameter int INIT_CLEAR = 1,
    parameter int RO_TIMEOUT = 16
) (
    input  logic               core_clk,
    input  logic               core_rstn,
    mgmt_soc_ram_arb_if.slave  bus,
    input  logic               soft_clear,
    output logic               init_busy
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int NB     = lane_cnt(DATA_W);
    localparam ram_state_e RST_ST = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
    localparam logic [ADDR_W-1:0]   LAST = ADDR_W'(DEPTH - 1);
    localparam logic [STARVE_W-1:0] TMO  = STARVE_W'(RO_TIMEOUT);

    ram_state_e          state, state_nxt;
    logic [ADDR_W-1:0]   clr_ptr, ptr_nxt;
    logic [STARVE_W-1:0] starve;
    logic                clearing, xfer;
    logic [NB-1:0]       wr_we;
    logic [ADDR_W-1:0]   wr_a;
    logic [DATA_W-1:0]   wr_d;

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state   <= RST_ST;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = clr_ptr;
        case (state)
            ST_CLEAR: begin
                ptr_nxt = clr_ptr + ADDR_W'(1);
                if (clr_ptr == LAST) begin
                    state_nxt = ST_READY;
                    ptr_nxt   = '0;
                end
            end
            ST_READY: begin
                if (soft_clear) begin
                    state_nxt = ST_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            default: state_nxt = RST_ST;
        endcase
    end

    assign clearing  = (state == ST_CLEAR);
    assign init_busy = clearing;

    // The clear engine takes the write port outright; SoC writes are dropped then.
    assign wr_we = clearing ? '1 : (bus.soc_en ? bus.soc_we : '0);
    assign wr_a  = clearing ? clr_ptr : bus.soc_a;
    assign wr_d  = clearing ? '0 : bus.soc_di;

    assign bus.ro_ready = ~bus.soc_en & ~clearing;
    assign xfer         = bus.ro_req & bus.ro_ready;

    mgmt_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk    (core_clk),
        .rst_n  (core_rstn),
        .we     (wr_we),
        .wa     (wr_a),
        .wd     (wr_d),
        .a_en   (bus.soc_en),
        .a_zero (clearing),
        .a_addr (bus.soc_a),
        .a_do   (bus.soc_do),
        .b_en   (xfer),
        .b_addr (bus.ro_addr),
        .b_do   (bus.ro_data)
    );

    // Starvation counter wraps after signalling so a held ro_req re-arms the timeout.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            starve       <= '0;
            bus.ro_err   <= 1'b0;
            bus.ro_valid <= 1'b0;
        end else begin
            bus.ro_valid <= xfer;
            bus.ro_err   <= 1'b0;
            if (!bus.ro_req || xfer) begin
                starve <= '0;
            end else if (starve == TMO - STARVE_W'(1)) begin
                starve     <= '0;
                bus.ro_err <= 1'b1;
            end else begin
                starve <= starve + STARVE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mgmt_soc_ram_arb.sv
// Directed bench for mgmt_soc_ram_arb with a cycle-level reference model.
module tb_mgmt_soc_ram_arb;
    localparam int RO_T = 16;

    logic clk = 1'b0;
    logic rstn;
    logic soft_clear = 1'b0;
    logic busy0, busy1;
    int   checks = 0;
    int   failures = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;

    mgmt_soc_ram_arb_if #(.DATA_W(32), .ADDR_W(8)) if0 ();
    mgmt_soc_ram_arb_if #(.DATA_W(32), .ADDR_W(8)) if1 ();

    mgmt_soc_ram_arb #(.DATA_W(32), .DEPTH(256), .INIT_CLEAR(1), .RO_TIMEOUT(RO_T)) dut (
        .core_clk(clk), .core_rstn(rstn), .bus(if0.slave),
        .soft_clear(soft_clear), .init_busy(busy0));

    mgmt_soc_ram_arb #(.DATA_W(32), .DEPTH(200), .INIT_CLEAR(1), .RO_TIMEOUT(RO_T)) dut2 (
        .core_clk(clk), .core_rstn(rstn), .bus(if1.slave),
        .soft_clear(1'b0), .init_busy(busy1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    // Reference model for the DEPTH=256 instance: memory image plus the
    // observable outputs, advanced once per clock from the sampled inputs.
    logic [31:0] m_mem [256];
    int          m_ptr, m_starve;
    bit          m_busy, m_ro_valid, m_ro_err;
    logic [31:0] m_soc_do, m_ro_data;

    initial for (int i = 0; i < 256; i++) m_mem[i] = '0;

    always @(posedge clk or negedge rstn) begin
        bit xfer;
        if (!rstn) begin
            m_busy = 1; m_ptr = 0; m_starve = 0;
            m_soc_do = '0; m_ro_data = '0; m_ro_valid = 0; m_ro_err = 0;
        end else begin
            xfer = if0.ro_req && !if0.soc_en && !m_busy;
            m_ro_valid = xfer;
            m_ro_err   = 0;
            if (xfer) m_ro_data = m_mem[if0.ro_addr];
            if (if0.soc_en) m_soc_do = m_busy ? 32'h0 : m_mem[if0.soc_a];
            if (!if0.ro_req || xfer) m_starve = 0;
            else begin
                m_starve++;
                if (m_starve == RO_T) begin m_ro_err = 1; m_starve = 0; end
            end
            if (m_busy) begin
                m_mem[m_ptr] = '0;
                if (m_ptr == 255) m_busy = 0;
                m_ptr++;
            end else begin
                if (if0.soc_en)
                    for (int b = 0; b < 4; b++)
                        if (if0.soc_we[b]) m_mem[if0.soc_a][b*8 +: 8] = if0.soc_di[b*8 +: 8];
                if (soft_clear) begin m_busy = 1; m_ptr = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk1("init_busy", busy0, m_busy);
            chk1("ro_ready", if0.ro_ready, !if0.soc_en && !m_busy);
            chk1("ro_valid", if0.ro_valid, m_ro_valid);
            chk1("ro_err", if0.ro_err, m_ro_err);
            chk("soc_do", if0.soc_do, m_soc_do);
            chk("ro_data", if0.ro_data, m_ro_data);
        end
    end

    task automatic idle0();
        if0.soc_en = 0; if0.soc_we = '0; if0.soc_a = '0; if0.soc_di = '0;
        if0.ro_req = 0; if0.ro_addr = '0;
    endtask

    task automatic readback_all(input string nm);
        int nz = 0;
        for (int a = 0; a < 256; a++) begin
            if0.soc_en = 1; if0.soc_we = '0; if0.soc_a = 8'(a);
            nxt();
            if (if0.soc_do != 0) nz++;
        end
        if0.soc_en = 0;
        chk(nm, nz, 0);
    endtask

    task automatic count_busy(input string nm, input bit inject);
        int n = 0;
        while (n < 400) begin
            if (inject && n == 20) begin
                if0.soc_en = 1; if0.soc_we = 4'hF; if0.soc_a = 8'd3; if0.soc_di = 32'hFFFF_FFFF;
            end
            nxt();
            n++;
            if (inject && n == 21) begin
                chk("clear_soc_do", if0.soc_do, 32'h0);
                if0.soc_en = 0; if0.soc_we = '0;
            end
            if (!busy0) break;
        end
        chk(nm, n, 256);
    endtask

    initial begin
        int vc, errs, errk, vbad, guard;
        rstn = 0;
        idle0();
        if1.soc_en = 0; if1.soc_we = '0; if1.soc_a = '0; if1.soc_di = '0;
        if1.ro_req = 0; if1.ro_addr = '0;
        repeat (3) nxt();
        chk1("rst_init_busy", busy0, 1'b1);
        chk1("rst_ro_valid", if0.ro_valid, 1'b0);
        chk1("rst_ro_err", if0.ro_err, 1'b0);
        chk("rst_soc_do", if0.soc_do, 32'h0);
        chk("rst_ro_data", if0.ro_data, 32'h0);
        chk_on = 1;
        rstn = 1;

        count_busy("init_busy_cycles", 1'b1);
        readback_all("post_init_zero");

        // Full write, byte-lane write, read back.
        if0.soc_en = 1; if0.soc_we = 4'hF; if0.soc_a = 8'd5; if0.soc_di = 32'hDEAD_BEEF;
        nxt(); chk("wr1_prev", if0.soc_do, 32'h0);
        if0.soc_we = 4'b0010; if0.soc_di = 32'h0000_1200;
        nxt(); chk("wr2_read_first", if0.soc_do, 32'hDEAD_BEEF);
        if0.soc_we = '0;
        nxt(); chk("rd5", if0.soc_do, 32'hDEAD_12EF);
        if0.soc_en = 0;
        nxt(); chk("soc_do_hold", if0.soc_do, 32'hDEAD_12EF);

        // Housekeeping read while the SoC strobes every other cycle.
        vc = 0;
        if0.ro_req = 1; if0.ro_addr = 8'd5; if0.soc_a = 8'd5;
        for (int i = 0; i < 10; i++) begin
            if0.soc_en = (i % 2 == 0);
            nxt();
            if (if0.ro_valid) begin
                vc++;
                chk("toggle_ro_data", if0.ro_data, 32'hDEAD_12EF);
            end
        end
        chk("toggle_valid_cnt", vc, 5);
        if0.ro_req = 0; if0.soc_en = 0;
        nxt();

        // Starvation: SoC holds the RAM for 20 cycles.
        errs = 0; errk = 0; vbad = 0;
        if0.soc_en = 1; if0.ro_req = 1;
        for (int k = 1; k <= 20; k++) begin
            nxt();
            if (if0.ro_err) begin errs++; errk = k; end
            if (if0.ro_valid) vbad++;
        end
        chk("starve_err_cnt", errs, 1);
        chk("starve_err_cycle", errk, 16);
        chk("starve_no_valid", vbad, 0);
        if0.soc_en = 0;
        nxt();
        chk1("starve_release_valid", if0.ro_valid, 1'b1);
        chk("starve_release_data", if0.ro_data, 32'hDEAD_12EF);
        if0.ro_req = 0;
        nxt();

        // Soft clear, then reset in the middle of the clear.
        soft_clear = 1;
        nxt();
        soft_clear = 0;
        chk1("soft_clear_busy", busy0, 1'b1);
        guard = 0;
        while (m_ptr != 100 && guard < 400) begin nxt(); guard++; end
        chk("reach_ptr100", m_ptr, 100);
        rstn = 0;
        nxt();
        chk1("midclear_rst_busy", busy0, 1'b1);
        rstn = 1;
        count_busy("restart_busy_cycles", 1'b0);
        readback_all("post_restart_zero");

        // Out-of-range access on the DEPTH=200 instance.
        chk1("d200_ready", busy1, 1'b0);
        if1.soc_en = 1; if1.soc_we = 4'hF; if1.soc_a = 8'd10; if1.soc_di = 32'h1122_3344;
        nxt();
        if1.soc_a = 8'd210; if1.soc_di = 32'hCAFE_F00D;
        nxt();
        if1.soc_en = 0; if1.soc_we = '0;
        if1.ro_req = 1; if1.ro_addr = 8'd10;
        nxt();
        chk1("d200_ro_valid10", if1.ro_valid, 1'b1);
        chk("d200_ro_data10", if1.ro_data, 32'h1122_3344);
        if1.ro_addr = 8'd210;
        nxt();
        chk1("d200_ro_valid210", if1.ro_valid, 1'b1);
        chk("d200_ro_data210", if1.ro_data, 32'h0);
        if1.ro_req = 0;
        if1.soc_en = 1; if1.soc_a = 8'd10;
        nxt(); chk("d200_soc_do10", if1.soc_do, 32'h1122_3344);
        if1.soc_a = 8'd210;
        nxt(); chk("d200_soc_do210", if1.soc_do, 32'h0);
        if1.soc_a = 8'd10;
        nxt(); chk("d200_addr10_kept", if1.soc_do, 32'h1122_3344);
        if1.soc_en = 0;
        nxt();

        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
